// File: rtl/bus_demux2_pkg.sv
// Shared types and constants for the two-target request demultiplexer.
package bus_demux2_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 word multiplexer.
module mux2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  // Select in1 when sel is high, otherwise in0.
  always_comb begin
    out_o = sel_i ? in1_i : in0_i;
  end

endmodule

// File: rtl/bus_demux2.sv
// Splits one CPU request stream between data RAM (port A) and MMIO (port B),
// one transaction outstanding, with a wait timeout and sticky error flags.
module bus_demux2
  import bus_demux2_pkg::*;
#(
  parameter int unsigned          WIDTH      = 32,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          SEL_BIT    = 14,
  parameter int unsigned          TIMEOUT    = 255,
  parameter logic [WIDTH-1:0]     ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [WIDTH-1:0]      s_wdata,
  input  logic                  s_we,
  output logic                  s_rvalid,
  output logic [WIDTH-1:0]      s_rdata,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [WIDTH-1:0]      a_wdata,
  output logic                  a_we,
  input  logic                  a_rvalid,
  input  logic [WIDTH-1:0]      a_rdata,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [ADDR_WIDTH-1:0] b_addr,
  output logic [WIDTH-1:0]      b_wdata,
  output logic                  b_we,
  input  logic                  b_rvalid,
  input  logic [WIDTH-1:0]      b_rdata,
  output logic                  timeout_err,
  output logic                  stray_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  dest_q, dest_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  terr_q, terr_d;
  logic                  stray_q, stray_d;

  logic                  in_wait;
  logic                  dest_ready;
  logic                  dest_rvalid;
  logic                  timeout_hit;
  logic                  stray_now;
  logic [WIDTH-1:0]      sel_rdata;
  logic [WIDTH-1:0]      resp_data;

  assign in_wait     = (state_q == StWait);
  assign dest_ready  = (dest_q == PORT_B) ? b_ready : a_ready;
  assign dest_rvalid = in_wait & ((dest_q == PORT_B) ? b_rvalid : a_rvalid);
  // Real data on the final wait cycle beats the timeout.
  assign timeout_hit = in_wait & ~dest_rvalid & (cnt_q >= CntW'(TIMEOUT - 1));
  // Any rvalid not from the dest port while waiting is unexpected.
  assign stray_now   = (a_rvalid & ~(in_wait & (dest_q == PORT_A))) |
                       (b_rvalid & ~(in_wait & (dest_q == PORT_B)));

  mux2 #(
    .WIDTH(WIDTH)
  ) u_rdata_mux (
    .in0_i(a_rdata),
    .in1_i(b_rdata),
    .sel_i(dest_q),
    .out_o(sel_rdata)
  );

  assign resp_data = timeout_hit ? ERR_DATA : sel_rdata;

  // Next-state and response logic for the IDLE/ISSUE/WAIT handshake sequence.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    dest_d   = dest_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    terr_d   = terr_q;
    stray_d  = stray_q | stray_now;

    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          addr_d  = s_addr;
          wdata_d = s_wdata;
          we_d    = s_we;
          dest_d  = s_addr[SEL_BIT];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (dest_ready) begin
          cnt_d   = '0;
          state_d = we_q ? StIdle : StWait;
        end
      end
      StWait: begin
        if (dest_rvalid || timeout_hit) begin
          rvalid_d = 1'b1;
          rdata_d  = resp_data;
          terr_d   = terr_q | timeout_hit;
          state_d  = StIdle;
        end else if (cnt_q != CntW'(TIMEOUT)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      dest_q   <= PORT_A;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      terr_q   <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      terr_q   <= terr_d;
      stray_q  <= stray_d;
    end
  end

  // Request fields fan out to both ports; only the dest port sees valid.
  always_comb begin
    s_ready     = (state_q == StIdle) & rst_n;
    a_valid     = (state_q == StIssue) & (dest_q == PORT_A);
    b_valid     = (state_q == StIssue) & (dest_q == PORT_B);
    a_addr      = addr_q;
    b_addr      = addr_q;
    a_wdata     = wdata_q;
    b_wdata     = wdata_q;
    a_we        = we_q;
    b_we        = we_q;
    s_rvalid    = rvalid_q;
    s_rdata     = rdata_q;
    timeout_err = terr_q;
    stray_err   = stray_q;
  end

endmodule
